// File: rtl/bin_dec_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Contents: FSM state enum, weight index type and weight lookup,
// digit bundle struct, and the leading-zero blanking helper.
package bin_dec_pkg;

    localparam int unsigned BIN_W   = 16;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    localparam logic [BIN_W-1:0] W_10000 = 16'd10000;
    localparam logic [BIN_W-1:0] W_1000  = 16'd1000;
    localparam logic [BIN_W-1:0] W_100   = 16'd100;
    localparam logic [BIN_W-1:0] W_10    = 16'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    // Five BCD digits, most significant first.
    typedef struct packed {
        logic [DIGIT_W-1:0] d4;
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } dec_digits_t;

    // Weight selected by the digit index: 0 -> 10000 ... 3 -> 10.
    function automatic logic [BIN_W-1:0] weight_of(input idx_t idx);
        logic [BIN_W-1:0] w;
        case (idx)
            2'd0:    w = W_10000;
            2'd1:    w = W_1000;
            2'd2:    w = W_100;
            default: w = W_10;
        endcase
        return w;
    endfunction

    // Replace leading zeros (d4 down to d1) with the blank code; d0 always shown.
    function automatic dec_digits_t blank_leading(input dec_digits_t d);
        dec_digits_t r;
        r = d;
        if (r.d4 == '0) begin
            r.d4 = BLANK_CODE;
            if (r.d3 == '0) begin
                r.d3 = BLANK_CODE;
                if (r.d2 == '0) begin
                    r.d2 = BLANK_CODE;
                    if (r.d1 == '0) begin
                        r.d1 = BLANK_CODE;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_dec_seq_if.sv
// Handshake and result bus of the binary-to-BCD converter.
// master: requester (drives START/BIN_IN, observes BUSY/DONE/digits).
// slave : converter (the reverse).
interface bin_dec_seq_if;
    import bin_dec_pkg::*;

    logic                 START;
    logic [BIN_W-1:0]     BIN_IN;
    logic                 BUSY;
    logic                 DONE;
    logic [DIGIT_W-1:0]   DEC_OUT4;
    logic [DIGIT_W-1:0]   DEC_OUT3;
    logic [DIGIT_W-1:0]   DEC_OUT2;
    logic [DIGIT_W-1:0]   DEC_OUT1;
    logic [DIGIT_W-1:0]   DEC_OUT0;

    modport master (
        output START, BIN_IN,
        input  BUSY, DONE, DEC_OUT4, DEC_OUT3, DEC_OUT2, DEC_OUT1, DEC_OUT0
    );

    modport slave (
        input  START, BIN_IN,
        output BUSY, DONE, DEC_OUT4, DEC_OUT3, DEC_OUT2, DEC_OUT1, DEC_OUT0
    );
endinterface

// File: rtl/bin_dec_step.sv
// Shared compare/subtract stage: ge_c = (rem >= weight), diff_c = rem - weight.
// Ports: rem, weight (inputs); ge_c, diff_c (combinational outputs).
// diff_c is only meaningful when ge_c is high; the caller ignores it otherwise.
module bin_dec_step
    import bin_dec_pkg::*;
(
    input  logic [BIN_W-1:0] rem,
    input  logic [BIN_W-1:0] weight,
    output logic             ge_c,
    output logic [BIN_W-1:0] diff_c
);

    always_comb begin
        ge_c   = (rem >= weight);
        diff_c = rem - weight;
    end

endmodule

// File: rtl/bin_dec_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (one subtraction per clock).
// Ports: CLK, RESET (sync, active-high), bus (bin_dec_seq_if.slave):
//   START/BIN_IN request, BUSY during conversion, DONE on result,
//   DEC_OUT4..DEC_OUT0 result digits (updated only on completion).
// Parameter STICKY_DONE: 0 = one-cycle DONE pulse, 1 = DONE held until next START.
// Optional macro BIN_DEC_SEQ_BLANK_EN: leading zero digits shown as blank code.
module bin_dec_seq
    import bin_dec_pkg::*;
#(
    parameter bit STICKY_DONE = 1'b0
)(
    input  logic             CLK,
    input  logic             RESET,
    bin_dec_seq_if.slave     bus
);

    state_t             state;
    logic [BIN_W-1:0]   rem;
    idx_t               idx;
    logic [DIGIT_W-1:0] cnt;
    logic [DIGIT_W-1:0] sh4, sh3, sh2;
    logic               busy_q;
    logic               done_q;
    dec_digits_t        dec_q;
    dec_digits_t        dig_c;

    logic               ge_c;
    logic [BIN_W-1:0]   diff_c;

    bin_dec_step u_step (
        .rem    (rem),
        .weight (weight_of(idx)),
        .ge_c   (ge_c),
        .diff_c (diff_c)
    );

    // Digits as they stand at the last CONV step: tens come straight from cnt,
    // ones from the remainder, which is below 10 once the tens pass ends.
    always_comb begin
        dig_c    = '0;
        dig_c.d4 = sh4;
        dig_c.d3 = sh3;
        dig_c.d2 = sh2;
        dig_c.d1 = cnt;
        dig_c.d0 = rem[DIGIT_W-1:0];
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            rem    <= '0;
            idx    <= '0;
            cnt    <= '0;
            sh4    <= '0;
            sh3    <= '0;
            sh2    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dec_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        rem    <= bus.BIN_IN;
                        idx    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    if (ge_c) begin
                        rem <= diff_c;
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt <= '0;
                        case (idx)
                            2'd0: sh4 <= cnt;
                            2'd1: sh3 <= cnt;
                            2'd2: sh2 <= cnt;
                            default: ;
                        endcase
                        if (idx == 2'd3) begin
`ifdef BIN_DEC_SEQ_BLANK_EN
                            dec_q <= blank_leading(dig_c);
`else
                            dec_q <= dig_c;
`endif
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                FIN: begin
                    // Sticky mode keeps DONE until the next accepted START.
                    if (!STICKY_DONE) begin
                        done_q <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.DEC_OUT4 = dec_q.d4;
    assign bus.DEC_OUT3 = dec_q.d3;
    assign bus.DEC_OUT2 = dec_q.d2;
    assign bus.DEC_OUT1 = dec_q.d1;
    assign bus.DEC_OUT0 = dec_q.d0;

endmodule

// File: tb/tb_bin_dec_seq.sv
// Directed bench for bin_dec_seq: table of values with hand-computed digits
// and CONV lengths, plus back-to-back, mid-conversion reset and sticky DONE.
module tb_bin_dec_seq;

    logic CLK;
    logic RESET;

    bin_dec_seq_if ifa ();
    bin_dec_seq_if ifs ();

    bin_dec_seq #(.STICKY_DONE(1'b0)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ifa.slave)
    );

    bin_dec_seq #(.STICKY_DONE(1'b1)) u_sticky (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ifs.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] dig;
        int          conv;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected display form of a raw BCD result.
    function automatic logic [19:0] disp(input logic [19:0] raw);
        logic [19:0] r;
        r = raw;
`ifdef BIN_DEC_SEQ_BLANK_EN
        for (int i = 4; i >= 1; i--) begin
            if (r[i*4 +: 4] != 4'd0) break;
            r[i*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [19:0] dig_a();
        return {ifa.DEC_OUT4, ifa.DEC_OUT3, ifa.DEC_OUT2, ifa.DEC_OUT1, ifa.DEC_OUT0};
    endfunction

    function automatic logic [19:0] dig_s();
        return {ifs.DEC_OUT4, ifs.DEC_OUT3, ifs.DEC_OUT2, ifs.DEC_OUT1, ifs.DEC_OUT0};
    endfunction

    // Called at the first negedge after the accept edge; counts BUSY cycles.
    task automatic wait_busy_a(output int cyc);
        cyc = 0;
        while (ifa.BUSY && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
    endtask

    task automatic wait_busy_s(output int cyc);
        cyc = 0;
        while (ifs.BUSY && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
    endtask

    // One full conversion on the non-sticky instance.
    task automatic run_vec(input logic [15:0] bin, input logic [19:0] raw, input int conv);
        int cyc;
        @(negedge CLK);
        ifa.START  = 1'b1;
        ifa.BIN_IN = bin;
        @(negedge CLK);
        ifa.START  = 1'b0;
        ifa.BIN_IN = ~bin;
        wait_busy_a(cyc);
        chk($sformatf("conv_cycles[%0d]", bin), 32'(cyc), 32'(conv));
        chk($sformatf("done_rise[%0d]", bin), 32'(ifa.DONE), 32'd1);
        chk($sformatf("busy_in_fin[%0d]", bin), 32'(ifa.BUSY), 32'd0);
        chk($sformatf("digits[%0d]", bin), 32'(dig_a()), 32'(disp(raw)));
        @(negedge CLK);
        chk($sformatf("done_fall[%0d]", bin), 32'(ifa.DONE), 32'd0);
        chk($sformatf("digits_hold[%0d]", bin), 32'(dig_a()), 32'(disp(raw)));
    endtask

    initial begin
        int cyc;
        logic seen;

        vecs[0] = '{16'd0,     20'h00000, 4};
        vecs[1] = '{16'd65535, 20'h65535, 23};
        vecs[2] = '{16'd59999, 20'h59999, 36};
        vecs[3] = '{16'd10000, 20'h10000, 5};
        vecs[4] = '{16'd9999,  20'h09999, 31};
        vecs[5] = '{16'd100,   20'h00100, 5};
        vecs[6] = '{16'd42,    20'h00042, 8};
        vecs[7] = '{16'd9,     20'h00009, 4};

        RESET      = 1'b1;
        ifa.START  = 1'b0;
        ifa.BIN_IN = '0;
        ifs.START  = 1'b0;
        ifs.BIN_IN = '0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", 32'(ifa.BUSY), 32'd0);
        chk("reset_done", 32'(ifa.DONE), 32'd0);
        chk("reset_digits", 32'(dig_a()), 32'd0);
        chk("reset_sticky_done", 32'(ifs.DONE), 32'd0);
        RESET = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].bin, vecs[i].dig, vecs[i].conv);
        end

        // Back-to-back with START held; BIN_IN changes after acceptance.
        @(negedge CLK);
        ifa.START  = 1'b1;
        ifa.BIN_IN = 16'd1234;
        @(negedge CLK);
        ifa.BIN_IN = 16'd4321;
        wait_busy_a(cyc);
        chk("b2b_first_cycles", 32'(cyc), 32'd10);
        chk("b2b_first_done", 32'(ifa.DONE), 32'd1);
        chk("b2b_first_digits", 32'(dig_a()), 32'(disp(20'h01234)));
        @(negedge CLK);
        chk("b2b_idle_busy", 32'(ifa.BUSY), 32'd0);
        chk("b2b_idle_done", 32'(ifa.DONE), 32'd0);
        @(negedge CLK);
        chk("b2b_second_busy", 32'(ifa.BUSY), 32'd1);
        ifa.START = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (ifa.BUSY && cyc < 100) begin
            if (dig_a() !== disp(20'h01234)) seen = 1'b1;
            if (cyc == 2) begin
                ifa.START  = 1'b1;
                ifa.BIN_IN = 16'd999;
            end
            if (cyc == 5) ifa.START = 1'b0;
            cyc++;
            @(negedge CLK);
        end
        chk("b2b_digits_held", 32'(seen), 32'd0);
        chk("b2b_second_cycles", 32'(cyc), 32'd13);
        chk("b2b_second_done", 32'(ifa.DONE), 32'd1);
        chk("b2b_second_digits", 32'(dig_a()), 32'(disp(20'h04321)));
        @(negedge CLK);
        @(negedge CLK);
        chk("b2b_no_queue_busy", 32'(ifa.BUSY), 32'd0);
        chk("b2b_no_queue_done", 32'(ifa.DONE), 32'd0);

        // Reset in the middle of a conversion.
        ifa.START  = 1'b1;
        ifa.BIN_IN = 16'd54321;
        @(negedge CLK);
        ifa.START = 1'b0;
        repeat (5) @(negedge CLK);
        chk("abort_busy_before", 32'(ifa.BUSY), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_busy", 32'(ifa.BUSY), 32'd0);
        chk("abort_done", 32'(ifa.DONE), 32'd0);
        chk("abort_digits", 32'(dig_a()), 32'd0);
        RESET = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (ifa.DONE || ifa.BUSY) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_vec(16'd7, 20'h00007, 4);

        // Sticky DONE instance.
        @(negedge CLK);
        ifs.START  = 1'b1;
        ifs.BIN_IN = 16'd42;
        @(negedge CLK);
        ifs.START = 1'b0;
        wait_busy_s(cyc);
        chk("sticky_cycles", 32'(cyc), 32'd8);
        chk("sticky_done", 32'(ifs.DONE), 32'd1);
        chk("sticky_digits", 32'(dig_s()), 32'(disp(20'h00042)));
        seen = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (!ifs.DONE) seen = 1'b1;
        end
        chk("sticky_done_held", 32'(seen), 32'd0);
        ifs.START  = 1'b1;
        ifs.BIN_IN = 16'd100;
        @(negedge CLK);
        ifs.START = 1'b0;
        chk("sticky_done_cleared", 32'(ifs.DONE), 32'd0);
        chk("sticky_busy_again", 32'(ifs.BUSY), 32'd1);
        chk("sticky_digits_hold", 32'(dig_s()), 32'(disp(20'h00042)));
        wait_busy_s(cyc);
        chk("sticky2_cycles", 32'(cyc), 32'd5);
        chk("sticky2_done", 32'(ifs.DONE), 32'd1);
        chk("sticky2_digits", 32'(dig_s()), 32'(disp(20'h00100)));
        repeat (3) @(negedge CLK);
        chk("sticky2_done_held", 32'(ifs.DONE), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_dec_seq.md
Name: bin_dec_seq

Overview:
- Sequential 16-bit binary to 5-digit BCD converter for the CPU's decimal display path.
- One shared compare/subtract stage is time-multiplexed across the weights 10000, 1000, 100 and 10. Each clock performs one subtraction.
- START/BUSY/DONE handshake. Digits are presented together, only on completion.

Parameters:
- STICKY_DONE, 0, 0: DONE is a one-cycle pulse. 1: DONE stays high until the next accepted START or reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  conversion request; sampled only in IDLE.
- BIN_IN  input  16  unsigned value; latched when START is accepted.
- BUSY  output  1  high while a conversion is in progress (state CONV).
- DONE  output  1  result valid indication; see STICKY_DONE.
- DEC_OUT4  output  4  ten-thousands digit (0-6).
- DEC_OUT3  output  4  thousands digit.
- DEC_OUT2  output  4  hundreds digit.
- DEC_OUT1  output  4  tens digit.
- DEC_OUT0  output  4  ones digit.

Behaviour:
- Reset: state IDLE. BUSY=0, DONE=0, all DEC_OUTx=0, internal remainder/index/count cleared. Reset mid-conversion aborts the conversion; no DONE is produced.
- States: IDLE, CONV, FIN.
- IDLE:
  - START=1 at an edge: rem<=BIN_IN, idx<=0 (weight 10000), cnt<=0, go to CONV.
  - With STICKY_DONE=1, accepting START also clears DONE.
- CONV, each edge:
  - If rem >= W[idx]: rem<=rem-W[idx], cnt<=cnt+1.
  - Else: shadow digit[idx]<=cnt, cnt<=0.
    - If idx==3: ones<=rem[3:0] (rem<10 is guaranteed here), go to FIN.
    - Otherwise idx<=idx+1.
- FIN:
  - DEC_OUT4..0 are loaded from the shadow digits at the CONV->FIN edge.
  - DONE=1 for this cycle. Next edge returns to IDLE.
  - With STICKY_DONE=1, DONE stays high in IDLE until START is accepted.
- Latency:
  - CONV lasts d4+d3+d2+d1+4 cycles.
  - DONE rises that many edges after the START-accept edge plus one.
  - Minimum: 0 -> 4 CONV cycles. Maximum over the 16-bit range: 59999 -> 5+9+9+9+4 = 36 CONV cycles.
- START rules:
  - START is ignored while BUSY=1 and in FIN. No queuing.
  - A START held high is re-accepted in the first IDLE cycle.
- Output stability: DEC_OUTx change only at the CONV->FIN edge (or reset). They hold the previous result throughout a new conversion.
- Arithmetic:
  - rem is 16 bits, cnt is 4 bits; no overflow is possible (cnt <= 9, d4 <= 6).
  - Comparison is unsigned. The subtraction is never performed when rem < W.
- BIN_IN changing after acceptance has no effect.

Optional Feature:
- Macro BIN_DEC_SEQ_BLANK_EN.
- When defined: at the FIN load, leading zero digits (DEC_OUT4 down to DEC_OUT1) are replaced by 4'hF (the blank code for the 7-segment decoder). Blanking stops at the first nonzero digit. DEC_OUT0 is never blanked.
- When undefined: raw digits, leading zeros shown as 0.

Decomposition:
- Package bin_dec_pkg:
  - state enum (IDLE, CONV, FIN).
  - weight constants 10000/1000/100/10 and a 2-bit index type.
  - DIGIT_W=4, BLANK_CODE=4'hF.
- Sub-module bin_dec_step: combinational rem >= W compare, rem-W subtract, and ge flag. It is instantiated once and fed W[idx] through a mux.
- The controller FSM, counters and output registers stay in bin_dec_seq.

Test Plan:
- Reset, then BIN_IN=0, START pulse -> BUSY for 4 cycles, DONE one cycle, digits 0,0,0,0,0. With BLANK_EN: F,F,F,F,0.
- BIN_IN=65535 -> digits 6,5,5,3,5. CONV lasts 23 cycles, DONE pulse once, BUSY=0 in the DONE cycle.
- BIN_IN=59999 -> 5,9,9,9,9 with 36 CONV cycles. BIN_IN=10000 -> 1,0,0,0,0.
- Back-to-back: START=1 held, BIN_IN=1234 then 4321 -> second result 4,3,2,1 is accepted in the IDLE after FIN. DEC_OUT holds 0,1,2,3,4 during the second conversion. Extra START pulses while BUSY are ignored.
- RESET asserted mid-conversion of 54321 -> next edge IDLE, outputs 0, no DONE. Fresh START with 7 -> 0,0,0,0,7.
- STICKY_DONE=1: 42 -> DONE stays high until the next START edge, then clears; the second result is valid at the new DONE.
